// File: rtl/fc_pkg.sv
// fc_pkg: shared types and constants for the frame capture controller.
//   FC_FRAME_W / FC_FRAME_H / FC_ADDR_W : default frame geometry and BRAM address width
//   DATA_W                              : pixel width (RGB444)
//   FRAME_PIXELS                        : pixels per default frame
//   fc_state_e                          : controller FSM states
//   pixel_t / rd_beat_t                 : pixel and readout beat payloads
package fc_pkg;

    localparam int unsigned FC_FRAME_W   = 160;
    localparam int unsigned FC_FRAME_H   = 120;
    localparam int unsigned FC_ADDR_W    = 17;
    localparam int unsigned DATA_W       = 12;
    localparam int unsigned FRAME_PIXELS = FC_FRAME_W * FC_FRAME_H;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } fc_state_e;

    // One readout beat: pixel plus end-of-frame marker.
    typedef struct packed {
        logic   last;
        pixel_t data;
    } rd_beat_t;

endpackage

// File: rtl/fc_skid_fifo.sv
// fc_skid_fifo: 2-entry FIFO that absorbs BRAM read data behind a valid/ready consumer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : drop all contents (synchronous)
//   i_push         : write i_push_beat this cycle
//   i_ready        : consumer accepts the head beat when o_valid is high
//   o_valid        : FIFO not empty
//   o_beat         : head beat
//   o_count        : occupancy (0..2)
module fc_skid_fifo
    import fc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  rd_beat_t   i_push_beat,
    input  logic       i_ready,
    output logic       o_valid,
    output rd_beat_t   o_beat,
    output logic [1:0] o_count
);

    rd_beat_t   r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic       w_pop;
    logic       w_push;

    assign o_valid = (r_count != 2'd0);
    assign o_beat  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid & i_ready;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign w_push  = i_push & ((r_count != 2'd2) | w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: arms on start, captures one camera frame into a single-port BRAM
// starting at a vsync rising edge, then streams it out over valid/ready and returns idle.
//   clk25, rst            : clock, asynchronous active-low reset
//   start, abort          : capture request (IDLE only), return-to-idle (any state, wins)
//   vsync, pix_valid,
//   pix_data              : camera interface
//   mem_we, mem_addr,
//   mem_wdata, mem_rdata  : BRAM port (read data one cycle after address)
//   rd_valid, rd_ready,
//   rd_data, rd_last      : frame readout stream
//   busy, frame_done, ovf : status (not idle, end-of-readout pulse, sticky overrun)
module frame_capture_ctrl
    import fc_pkg::*;
#(
    parameter int unsigned FRAME_W = FC_FRAME_W,
    parameter int unsigned FRAME_H = FC_FRAME_H,
    parameter int unsigned ADDR_W  = FC_ADDR_W
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              vsync,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              frame_done,
    output logic              ovf
);

    localparam int unsigned       NPIX      = FRAME_W * FRAME_H;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(NPIX);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    fc_state_e         r_state;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_vsync_d;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_frame_done;
    logic              r_ovf;

    logic              w_fifo_valid;
    rd_beat_t          w_fifo_beat;
    rd_beat_t          w_push_beat;
    logic [1:0]        w_fifo_count;
    logic              w_pop;
    logic              w_issue;
    logic              w_wr;
    logic              w_last_hs;
    logic              w_vsync_rise;
    logic [2:0]        w_pending;

    assign w_wr         = (r_state == ST_CAPTURE) & pix_valid & (r_waddr < ADDR_END);
    assign w_pop        = w_fifo_valid & rd_ready;
    // Slots committed after this cycle's pop; counting the pop keeps one beat per cycle.
    assign w_pending    = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == ST_READOUT) & (r_raddr < ADDR_END) & (w_pending < 3'd2);
    assign w_last_hs    = w_pop & w_fifo_beat.last;
    assign w_vsync_rise = vsync & ~r_vsync_d;
    assign w_push_beat  = '{last: r_inflight_last, data: mem_rdata};

    fc_skid_fifo u_skid (
        .i_clk       (clk25),
        .i_rst_n     (rst),
        .i_flush     (abort),
        .i_push      (r_inflight),
        .i_push_beat (w_push_beat),
        .i_ready     (rd_ready),
        .o_valid     (w_fifo_valid),
        .o_beat      (w_fifo_beat),
        .o_count     (w_fifo_count)
    );

    // BRAM port mux: writer owns it in CAPTURE, reader in READOUT.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_CAPTURE: begin
                mem_we    = w_wr;
                mem_addr  = r_waddr;
                mem_wdata = w_wr ? pix_data : '0;
            end
            ST_READOUT: begin
                mem_addr = r_raddr;
            end
            default: ;
        endcase
    end

    assign rd_valid   = w_fifo_valid;
    assign rd_data    = w_fifo_valid ? w_fifo_beat.data : '0;
    assign rd_last    = w_fifo_valid & w_fifo_beat.last;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign ovf        = r_ovf;

    // Controller FSM with address counters and status flags.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_waddr         <= '0;
            r_raddr         <= '0;
            r_vsync_d       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_frame_done    <= 1'b0;
            r_ovf           <= 1'b0;
        end else begin
            r_vsync_d       <= vsync;
            r_frame_done    <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & (r_raddr == ADDR_LAST);

            if (abort) begin
                r_state    <= ST_IDLE;
                r_waddr    <= '0;
                r_raddr    <= '0;
                r_inflight <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_ARM;
                            r_ovf   <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        if (w_vsync_rise) begin
                            r_state <= ST_CAPTURE;
                            r_waddr <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (pix_valid && (r_waddr == ADDR_END)) begin
                            r_ovf <= 1'b1;
                        end
                        // Blanking before the frame is full: drop the partial frame.
                        if (!vsync) begin
                            r_waddr <= '0;
                        end else if (w_wr) begin
                            r_waddr <= r_waddr + ADDR_ONE;
                            if (r_waddr == ADDR_LAST) begin
                                r_state <= ST_READOUT;
                                r_raddr <= '0;
                            end
                        end
                    end
                    ST_READOUT: begin
                        // The buffer is still being read: a new pixel has nowhere to go.
                        if (pix_valid) begin
                            r_ovf <= 1'b1;
                        end
                        if (w_issue) begin
                            r_raddr <= r_raddr + ADDR_ONE;
                        end
                        if (w_last_hs) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: scoreboard bench for frame_capture_ctrl on a reduced 20x10 frame.
module tb_frame_capture_ctrl;
    import fc_pkg::*;

    localparam int unsigned FW   = 20;
    localparam int unsigned FH   = 10;
    localparam int unsigned NPIX = FW * FH;
    localparam int unsigned AW   = 17;
    localparam int unsigned DW   = DATA_W;

    logic          clk25 = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          vsync;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          frame_done;
    logic          ovf;

    always #20 clk25 = ~clk25;

    frame_capture_ctrl #(
        .FRAME_W (FW),
        .FRAME_H (FH),
        .ADDR_W  (AW)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .vsync      (vsync),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .busy       (busy),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    // Single-port BRAM model, read data one cycle after the address.
    logic [DW-1:0] bram [NPIX];
    always @(posedge clk25) begin
        if (mem_we && (int'(mem_addr) < int'(NPIX))) bram[int'(mem_addr)] <= mem_wdata;
        mem_rdata <= (int'(mem_addr) < int'(NPIX)) ? bram[int'(mem_addr)] : '0;
    end

    logic [AW+DW-1:0] q_wr [$];
    logic [DW:0]      q_rd [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats    = 0;
    int n_done   = 0;
    int last_wr_cyc = 0;
    int fd_cyc   = 0;
    int rd_mode  = 0;
    bit in_rd    = 1'b0;
    bit pend_fd  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pops, frame_done timing, outstanding reads.
    always @(negedge clk25) begin
        logic [AW+DW-1:0] ew;
        logic [DW:0]      er;
        bit               hs;
        int               diff;
        cyc++;
        if (rst) begin
            if (in_rd) begin
                if (!busy) begin
                    in_rd = 1'b0;
                end else begin
                    diff = int'(mem_addr) - beats;
                    check("outstanding", 32'(diff >= 0 && diff <= 2), 32'd1);
                end
            end
            if (mem_we) begin
                if (q_wr.size() == 0) begin
                    check("wr_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    ew = q_wr.pop_front();
                    check("wr", 32'({mem_addr, mem_wdata}), 32'(ew));
                end
                if (mem_addr == AW'(NPIX - 1)) begin
                    last_wr_cyc = cyc;
                    in_rd       = 1'b1;
                    beats       = 0;
                end
            end
            if (frame_done || pend_fd) begin
                check("frame_done", 32'(frame_done), 32'(pend_fd));
                if (pend_fd) check("busy_after_done", 32'(busy), 32'd0);
            end
            if (frame_done) begin
                n_done++;
                fd_cyc = cyc;
            end
            hs = rd_valid && rd_ready;
            if (hs) begin
                if (q_rd.size() == 0) begin
                    check("rd_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    er = q_rd.pop_front();
                    check("rd", 32'({rd_last, rd_data}), 32'(er));
                end
                beats++;
            end
            pend_fd = hs && rd_last;
        end
    end

    // Consumer ready: 0 = always ready, 1 = random 50%, 2 = stalled.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk25);
            #1;
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom_range(0, 1));
                default: rd_ready = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk25);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Start, hold vsync low in ARM, then raise it to open the frame.
    task automatic arm_and_sync();
        pulse_start();
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick();
    endtask

    task automatic drive_pixels(input int seed, input int n, input bit exp_reads);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_data  = DW'(i + seed);
            q_wr.push_back({AW'(i), DW'(i + seed)});
            if (exp_reads) q_rd.push_back({1'(i == int'(NPIX) - 1), DW'(i + seed)});
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int k;
        d0 = n_done;
        k  = 0;
        while (n_done == d0 && k < 5000) begin
            @(negedge clk25);
            k++;
        end
        check(tag, 32'(n_done > d0), 32'd1);
    endtask

    task automatic check_drained(input string tag);
        check(tag, 32'(q_wr.size() + q_rd.size()), 32'd0);
    endtask

    initial begin
        int d_before;
        int k;
        rst       = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        vsync     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        rd_mode   = 0;
        tick(3);
        @(negedge clk25);
        check("reset_outs", 32'({busy, mem_we, rd_valid, rd_last, frame_done, ovf}), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        tick();
        rst = 1'b1;
        tick(2);

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk25);
        check("start_abort_idle", 32'(busy), 32'd0);

        // capture then full-rate readout
        tick();
        arm_and_sync();
        check("busy_capture", 32'(busy), 32'd1);
        drive_pixels(0, int'(NPIX), 1'b1);
        @(negedge clk25);
        check("readout_state", 32'({busy, mem_we}), 32'b10);
        wait_done("done_full_rate");
        check_drained("drained_full_rate");
        check("beats_full_rate", 32'(beats), 32'(NPIX));
        check("latency_full_rate", 32'(fd_cyc - last_wr_cyc), 32'(NPIX + 3));
        check("idle_full_rate", 32'(busy), 32'd0);

        // random backpressure
        rd_mode = 1;
        tick();
        arm_and_sync();
        drive_pixels(300, int'(NPIX), 1'b1);
        wait_done("done_backpressure");
        check_drained("drained_backpressure");
        check("beats_backpressure", 32'(beats), 32'(NPIX));

        // vsync drops mid-capture: partial frame discarded
        rd_mode = 0;
        tick();
        arm_and_sync();
        drive_pixels(1000, 50, 1'b0);
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick();
        drive_pixels(2000, int'(NPIX), 1'b1);
        wait_done("done_restart");
        check_drained("drained_restart");
        check("ovf_restart", 32'(ovf), 32'd0);

        // abort mid-readout
        tick();
        arm_and_sync();
        drive_pixels(500, int'(NPIX), 1'b1);
        k = 0;
        while (beats < 100 && k < 2000) begin
            @(negedge clk25);
            k++;
        end
        check("abort_reached_beat", 32'(beats >= 100), 32'd1);
        d_before = n_done;
        @(posedge clk25);
        #1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q_rd.delete();
        @(negedge clk25);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        tick(3);
        check("abort_no_done", 32'(n_done), 32'(d_before));
        arm_and_sync();
        drive_pixels(0, int'(NPIX), 1'b1);
        wait_done("done_after_abort");
        check_drained("drained_after_abort");
        check("latency_after_abort", 32'(fd_cyc - last_wr_cyc), 32'(NPIX + 3));

        // pixels in ARM ignored; pixels in READOUT set ovf; start clears it
        rd_mode = 2;
        tick();
        pulse_start();
        vsync     = 1'b0;
        pix_valid = 1'b1;
        pix_data  = DW'(12'hABC);
        tick(2);
        pix_valid = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        drive_pixels(700, int'(NPIX), 1'b1);
        @(negedge clk25);
        check("ovf_before_overrun", 32'(ovf), 32'd0);
        tick();
        pix_valid = 1'b1;
        start     = 1'b1;
        tick();
        pix_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk25);
        check("ovf_set", 32'(ovf), 32'd1);
        check("start_busy_ignored", 32'(busy), 32'd1);
        rd_mode = 0;
        wait_done("done_overrun");
        check_drained("drained_overrun");
        check("ovf_sticky", 32'(ovf), 32'd1);
        tick();
        pulse_start();
        @(negedge clk25);
        check("ovf_cleared", 32'(ovf), 32'd0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk25);
        check("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
